// File: rtl/hc595_shift_ctrl.sv
// Serialises one {segment, select} word into two chained 74HC595s, MSB first,
// then pulses the storage clock and reports completion with a one-cycle done.
module hc595_shift_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int SEG_W   = 8,
    parameter int SEL_W   = 6
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [SEG_W-1:0] in_seg,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             disp_en,
    output logic             done,
    output logic             ds,
    output logic             shcp,
    output logic             stcp,
    output logic             oe
);

    localparam int WORD_W = SEG_W + SEL_W;
    localparam int DIV_W  = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(CLK_DIV);
    localparam logic [3:0]       LAST_BIT = 4'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t            state;
    logic [WORD_W-1:0] word;
    logic [3:0]        bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              loaded;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            word     <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            loaded   <= 1'b0;
            in_ready <= 1'b1;
            done     <= 1'b0;
            ds       <= 1'b0;
            shcp     <= 1'b0;
            stcp     <= 1'b0;
            oe       <= 1'b1;
        end else begin
            done <= 1'b0;
            // NOTE: non-blocking, so oe follows the loaded value from the previous cycle.
            oe   <= ~(disp_en & loaded);
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        word     <= {in_seg, in_sel};
                        ds       <= in_seg[SEG_W-1];
                        shcp     <= 1'b0;
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // div_cnt starts at 0 on accept, so bit 13 gets one extra low cycle.
                    if (div_cnt == DIV_END) begin
                        div_cnt <= DIV_W'(1);
                        if (!shcp) begin
                            shcp <= 1'b1;
                        end else begin
                            shcp <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                stcp  <= 1'b1;
                                state <= LATCH;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                ds      <= word[WORD_W-2];
                                word    <= word << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                LATCH: begin
                    if (div_cnt == DIV_END) begin
                        stcp     <= 1'b0;
                        loaded   <= 1'b1;
                        done     <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hc595_shift_ctrl.sv
// Scoreboard bench: three instances (CLK_DIV 2, 1, 5); stimulus queues expected
// words, per-instance monitors rebuild the serial word and timing on each done.
module tb_hc595_shift_ctrl;

    typedef struct packed {
        int          lane;
        logic [13:0] word;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       disp_en = 1'b1;
    logic [7:0] seg [3];
    logic [5:0] sel [3];
    logic [2:0] valid = '0;
    logic [2:0] ready, done, ds, shcp, stcp, oe;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   idle_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : 5;

        hc595_shift_ctrl #(.CLK_DIV(D)) dut (
            .sys_clk (clk),
            .sys_rst (rst),
            .in_seg  (seg[g]),
            .in_sel  (sel[g]),
            .in_valid(valid[g]),
            .in_ready(ready[g]),
            .disp_en (disp_en),
            .done    (done[g]),
            .ds      (ds[g]),
            .shcp    (shcp[g]),
            .stcp    (stcp[g]),
            .oe      (oe[g])
        );

        logic        p_shcp = 1'b0;
        logic        p_ready = 1'b1;
        logic        p_ds = 1'b0;
        logic        act = 1'b0;
        logic [13:0] word = '0;
        int          t_acc, rises, run, phase_bad, ds_bad, first_rise, stcp_first, stcp_n;
        exp_t        e;

        always begin
            @(posedge clk);
            #1;
            if (rst) begin
                act = 1'b0;
            end else if (p_ready && !ready[g]) begin
                act = 1'b1; t_acc = cyc; rises = 0; run = 0; phase_bad = 0; ds_bad = 0;
                first_rise = 0; stcp_first = 0; stcp_n = 0; word = '0;
            end else if (act) begin
                if (shcp[g] != p_shcp) begin
                    if (run != D && (p_shcp || rises > 0)) phase_bad++;
                    run = 1;
                    if (shcp[g]) begin
                        rises++;
                        word = {word[12:0], ds[g]};
                        if (rises == 1) first_rise = cyc - t_acc;
                    end
                end else begin
                    run++;
                end
                if (ds[g] !== p_ds && !(p_shcp && !shcp[g])) ds_bad++;
                if (stcp[g]) begin
                    if (stcp_n == 0) stcp_first = cyc - t_acc;
                    stcp_n++;
                end
                if (done[g]) begin
                    act = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("lane", g, e.lane);
                        check("word", word, e.word);
                        check("rises", rises, 14);
                        check("first_rise", first_rise, D + 1);
                        check("phase_len", phase_bad, 0);
                        check("ds_stable", ds_bad, 0);
                        check("stcp_start", stcp_first, 28 * D + 1);
                        check("stcp_len", stcp_n, D);
                        check("done_latency", cyc - t_acc, 29 * D + 1);
                    end
                end
            end else begin
                if (stcp[g] || done[g]) idle_bad++;
            end
            p_shcp  = shcp[g];
            p_ready = ready[g];
            p_ds    = ds[g];
        end
    end

    task automatic start(input int g, input logic [7:0] s, input logic [5:0] d,
                         input logic push, input logic [13:0] w);
        @(negedge clk);
        seg[g] = s;
        sel[g] = d;
        valid[g] = 1'b1;
        if (push) exp_q.push_back('{g, w});
        @(negedge clk);
        valid[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input string tag);
        int n = 0;
        while (n < 400 && done[g] !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done[g]), 1);
    endtask

    initial begin
        int   r, n, stcp_seen, oe_low, ready_hi;
        logic ps;
        for (int i = 0; i < 3; i++) begin
            seg[i] = '0;
            sel[i] = '0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready[0]), 1);
        check("rst_done", 32'(done[0]), 0);
        check("rst_ds", 32'(ds[0]), 0);
        check("rst_shcp", 32'(shcp[0]), 0);
        check("rst_stcp", 32'(stcp[0]), 0);
        check("rst_oe", 32'(oe[0]), 1);
        rst = 1'b0;

        // Single word, oe falls the cycle after done
        start(0, 8'hA5, 6'b000001, 1'b1, 14'h2941);
        wait_done(0, "t1");
        check("t1_oe_at_done", 32'(oe[0]), 1);
        @(negedge clk);
        check("t1_oe_after", 32'(oe[0]), 0);

        // Back-to-back with in_valid held
        @(negedge clk);
        seg[0] = 8'hFF; sel[0] = 6'h20; valid[0] = 1'b1;
        exp_q.push_back('{0, 14'h3FE0});
        exp_q.push_back('{0, 14'h0001});
        @(negedge clk);
        check("t2_busy", 32'(ready[0]), 0);
        seg[0] = 8'h00; sel[0] = 6'h01;
        wait_done(0, "t2a");
        check("t2_ready_at_done", 32'(ready[0]), 1);
        @(negedge clk);
        check("t2_second_accept", 32'(ready[0]), 0);
        valid[0] = 1'b0;
        wait_done(0, "t2b");

        // Input noise during SHIFT is ignored
        start(0, 8'h3C, 6'b000100, 1'b1, 14'h0F04);
        ready_hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            valid[0] = 1'($urandom);
            seg[0] = 8'($urandom);
            sel[0] = 6'($urandom);
            if (ready[0]) ready_hi++;
        end
        valid[0] = 1'b0;
        check("t3_ready_low", ready_hi, 0);
        wait_done(0, "t3");

        // Reset after the 7th shcp rise
        start(0, 8'h81, 6'h20, 1'b0, 14'h0);
        r = 0; n = 0; ps = 1'b0; stcp_seen = 0;
        while (r < 7 && n < 200) begin
            @(negedge clk);
            n++;
            if (shcp[0] && !ps) r++;
            ps = shcp[0];
            if (stcp[0]) stcp_seen++;
        end
        check("t4_rises_before_rst", r, 7);
        #2 rst = 1'b1;
        #1;
        check("t4_shcp", 32'(shcp[0]), 0);
        check("t4_stcp", 32'(stcp[0]), 0);
        check("t4_ds", 32'(ds[0]), 0);
        check("t4_done", 32'(done[0]), 0);
        check("t4_oe", 32'(oe[0]), 1);
        check("t4_ready", 32'(ready[0]), 1);
        check("t4_no_stcp", stcp_seen, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t4_oe_after_rst", 32'(oe[0]), 1);
        start(0, 8'h12, 6'b010000, 1'b1, 14'h0490);
        n = 0; oe_low = 0;
        while (n < 400 && done[0] !== 1'b1) begin
            @(negedge clk);
            n++;
            if (!oe[0]) oe_low++;
        end
        check("t4_done_seen", 32'(done[0]), 1);
        check("t4_oe_blank", oe_low, 0);
        @(negedge clk);
        check("t4_oe_after", 32'(oe[0]), 0);

        // disp_en gating
        disp_en = 1'b0;
        @(negedge clk);
        check("t5_oe_blank", 32'(oe[0]), 1);
        start(0, 8'hC3, 6'b001000, 1'b1, 14'h30C8);
        wait_done(0, "t5");
        @(negedge clk);
        check("t5_oe_still_blank", 32'(oe[0]), 1);
        disp_en = 1'b1;
        @(negedge clk);
        check("t5_oe_on", 32'(oe[0]), 0);
        disp_en = 1'b0;
        @(negedge clk);
        check("t5_oe_off", 32'(oe[0]), 1);
        disp_en = 1'b1;

        // Other divider settings
        start(1, 8'h5A, 6'b000010, 1'b1, 14'h1682);
        wait_done(1, "t6_d1");
        start(2, 8'h96, 6'b010000, 1'b1, 14'h2590);
        wait_done(2, "t6_d5");
        repeat (4) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        check("idle_pulses", idle_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
